relay_mode_sched: RTL and testbench

//  Sequences the HF front end during relay operation. Samples the relay link (dbg pin) at 847.5 kHz and

---
 rtl/relay_mode_sched_pkg.sv | 28 ++
 rtl/relay_mode_sched_deframer.sv | 46 ++++
 rtl/relay_mode_sched.sv | 121 ++++++++++++
 tb/tb_relay_mode_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/relay_mode_sched_pkg.sv
// relay_mode_sched_pkg: mode codes, relay framing patterns and FSM state encoding
package relay_mode_sched_pkg;

    localparam logic [2:0] SNIFFER       = 3'b000;
    localparam logic [2:0] TAGSIM_LISTEN = 3'b001;
    localparam logic [2:0] TAGSIM_MOD    = 3'b010;
    localparam logic [2:0] READER_LISTEN = 3'b011;
    localparam logic [2:0] READER_MOD    = 3'b100;
    localparam logic [2:0] FAKE_READER   = 3'b101;
    localparam logic [2:0] FAKE_TAG      = 3'b110;

    localparam logic [7:0]  READER_START_COMM  = 8'hC0;
    localparam logic [31:0] READER_END_COMM_1  = 32'h0000_0000;
    localparam logic [31:0] READER_END_COMM_2  = 32'hC000_0000;
    localparam logic [7:0]  TAG_START_COMM     = 8'hF0;
    localparam logic [23:0] TAG_END_COMM       = 24'h000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LISTEN,
        ST_MOD
    } state_e;

    function automatic logic [2:0] relay_code(input logic tag, input logic mod);
        return tag ? (mod ? TAGSIM_MOD : TAGSIM_LISTEN) : (mod ? READER_MOD : READER_LISTEN);
    endfunction

endpackage

// File: rtl/relay_mode_sched_deframer.sv
// relay_mode_sched_deframer: samples the relay link once per 16 clocks and flags start/end frame patterns
module relay_mode_sched_deframer
    import relay_mode_sched_pkg::*;
#(
    parameter logic [3:0] DIV_PHASE = 4'd8
) (
    input  logic ck_1356meg,
    input  logic reset,
    input  logic relay_in,
    input  logic clr,
    output logic bit_strobe,
    output logic tap,
    output logic start_rd,
    output logic start_tg,
    output logic end_rd,
    output logic end_tg
);

    logic [1:0]  sync;
    logic [3:0]  div;
    logic [31:0] sr;
    logic [31:0] sr_n;

    assign sr_n     = {sr[30:0], sync[1]};
    assign tap      = sr[15];
    assign start_rd = bit_strobe && sr_n[23:0] == {16'h0000, READER_START_COMM};
    assign start_tg = bit_strobe && sr_n[23:0] == {16'h0000, TAG_START_COMM};
    assign end_rd   = bit_strobe && (sr_n == READER_END_COMM_1 || sr_n == READER_END_COMM_2);
    assign end_tg   = bit_strobe && sr_n[23:0] == TAG_END_COMM;

    // synchronise the link, run the bit divider and shift one sample in per strobe
    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            sync       <= '0;
            div        <= '0;
            bit_strobe <= 1'b0;
            sr         <= '0;
        end else begin
            sync       <= {sync[0], relay_in};
            div        <= div + 4'd1;
            bit_strobe <= div == DIV_PHASE;
            sr         <= clr ? '0 : bit_strobe ? sr_n : sr;
        end
    end

endmodule

// File: rtl/relay_mode_sched.sv
// relay_mode_sched: LISTEN/MOD sequencing of the HF front end in relay modes (optional RELAY_TIMEOUT_EN)
module relay_mode_sched
    import relay_mode_sched_pkg::*;
#(
    parameter logic [3:0] DIV_PHASE         = 4'd8,
    parameter logic [7:0] MOD_TIMEOUT_BYTES = 8'd64
) (
    input  logic       ck_1356meg,
    input  logic       reset,
    input  logic [2:0] cfg_mod_type,
    input  logic       relay_in,
    input  logic       ssp_dout_arm,
    input  logic       ssp_din_raw,
    output logic [2:0] mod_type,
    output logic       hisn_ssp_dout,
    output logic       din_filtered,
    output logic       bit_strobe,
    output logic       in_mod,
    output logic       timeout
);

    state_e     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       relay, tag, tag_q, clr, tap;
    logic       start_rd, start_tg, end_rd, end_tg, start_hit, end_hit;
`ifdef RELAY_TIMEOUT_EN
    logic [7:0] byte_cnt, byte_cnt_n;
    logic       timeout_n;
`endif

    assign relay     = cfg_mod_type == FAKE_READER || cfg_mod_type == FAKE_TAG;
    assign tag       = cfg_mod_type == FAKE_TAG;
    assign start_hit = tag ? start_tg : start_rd;
    assign end_hit   = tag ? end_tg : end_rd;

    relay_mode_sched_deframer #(.DIV_PHASE(DIV_PHASE)) u_deframer (
        .ck_1356meg (ck_1356meg),
        .reset      (reset),
        .relay_in   (relay_in),
        .clr        (clr),
        .bit_strobe (bit_strobe),
        .tap        (tap),
        .start_rd   (start_rd),
        .start_tg   (start_tg),
        .end_rd     (end_rd),
        .end_tg     (end_tg)
    );

    // mode changes restart framing; otherwise strobes drive start/end/byte-boundary decisions
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        clr       = 1'b0;
`ifdef RELAY_TIMEOUT_EN
        byte_cnt_n = byte_cnt;
        timeout_n  = 1'b0;
`endif
        if (!relay) begin
            state_n = ST_IDLE;
            clr     = 1'b1;
        end else if (state == ST_IDLE || tag != tag_q) begin
            state_n   = ST_LISTEN;
            clr       = 1'b1;
            bit_cnt_n = '0;
        end else if (bit_strobe) begin
            if (start_hit) begin
                state_n   = ST_MOD;
                bit_cnt_n = '0;
`ifdef RELAY_TIMEOUT_EN
                byte_cnt_n = '0;
`endif
            end else begin
                bit_cnt_n = bit_cnt + 3'd1;
                if (state == ST_MOD && bit_cnt_n == 3'd0) begin
                    if (end_hit) begin
                        state_n = ST_LISTEN;
                    end
`ifdef RELAY_TIMEOUT_EN
                    else begin
                        byte_cnt_n = byte_cnt + 8'd1;
                        if (byte_cnt_n == MOD_TIMEOUT_BYTES) begin
                            state_n   = ST_LISTEN;
                            timeout_n = 1'b1;
                        end
                    end
`endif
                end
            end
        end
    end

    // state, bit alignment and the previous relay flavour used to spot reader/tag swaps
    always_ff @(posedge ck_1356meg) begin
        tag_q <= tag;
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
`ifdef RELAY_TIMEOUT_EN
            byte_cnt <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
`ifdef RELAY_TIMEOUT_EN
            byte_cnt <= byte_cnt_n;
            timeout  <= timeout_n;
`endif
        end
    end

`ifndef RELAY_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    assign in_mod        = state == ST_MOD;
    assign mod_type      = (relay && state != ST_IDLE) ? relay_code(tag_q, in_mod) : cfg_mod_type;
    assign hisn_ssp_dout = relay ? tap : ssp_dout_arm;
    assign din_filtered  = ssp_din_raw & (mod_type != TAGSIM_MOD);

endmodule

// File: tb/tb_relay_mode_sched.sv
// tb_relay_mode_sched: randomized relay traffic checked against a bit-level frame model
module tb_relay_mode_sched;

    localparam int TO_BYTES = 4;

    logic       ck_1356meg = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] cfg_mod_type = 3'b010;
    logic       relay_in = 1'b0;
    logic       ssp_dout_arm = 1'b0;
    logic       ssp_din_raw = 1'b0;
    logic [2:0] mod_type;
    logic       hisn_ssp_dout, din_filtered, bit_strobe, in_mod, timeout;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] m_hist;
    logic        m_mod, m_to;
    int          m_nbits, m_nbytes;

    relay_mode_sched #(.DIV_PHASE(4'd8), .MOD_TIMEOUT_BYTES(8'd4)) dut (
        .ck_1356meg    (ck_1356meg),
        .reset         (reset),
        .cfg_mod_type  (cfg_mod_type),
        .relay_in      (relay_in),
        .ssp_dout_arm  (ssp_dout_arm),
        .ssp_din_raw   (ssp_din_raw),
        .mod_type      (mod_type),
        .hisn_ssp_dout (hisn_ssp_dout),
        .din_filtered  (din_filtered),
        .bit_strobe    (bit_strobe),
        .in_mod        (in_mod),
        .timeout       (timeout)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_relay(input logic [2:0] c);
        return c == 3'b101 || c == 3'b110;
    endfunction

    function automatic logic [2:0] exp_mt();
        if (!is_relay(cfg_mod_type)) return cfg_mod_type;
        if (cfg_mod_type == 3'b110) return m_mod ? 3'b010 : 3'b001;
        return m_mod ? 3'b100 : 3'b011;
    endfunction

    task automatic model_clear();
        m_hist = '0;
        m_mod = 1'b0;
        m_to = 1'b0;
        m_nbits = 0;
        m_nbytes = 0;
    endtask

    task automatic model_bit(input logic b);
        logic tg, endm;
        m_to = 1'b0;
        if (!is_relay(cfg_mod_type)) return;
        tg = cfg_mod_type == 3'b110;
        m_hist = {m_hist[30:0], b};
        if (m_hist[23:0] == (tg ? 24'h0000F0 : 24'h0000C0)) begin
            m_mod = 1'b1;
            m_nbits = 0;
            m_nbytes = 0;
        end else begin
            m_nbits++;
            if (m_mod && m_nbits % 8 == 0) begin
                endm = tg ? (m_hist[23:0] == 24'h0) : (m_hist == 32'h0 || m_hist == 32'hC000_0000);
                if (endm) m_mod = 1'b0;
`ifdef RELAY_TIMEOUT_EN
                else begin
                    m_nbytes++;
                    if (m_nbytes == TO_BYTES) begin
                        m_mod = 1'b0;
                        m_to = 1'b1;
                    end
                end
`endif
            end
        end
    endtask

    task automatic check_outs(input string where);
        logic [2:0] mt;
        mt = exp_mt();
        chk({where, ".mod_type"}, 32'(mod_type), 32'(mt));
        chk({where, ".in_mod"}, 32'(in_mod), 32'(is_relay(cfg_mod_type) & m_mod));
        chk({where, ".timeout"}, 32'(timeout), 32'(m_to));
        chk({where, ".hisn"}, 32'(hisn_ssp_dout), 32'(is_relay(cfg_mod_type) ? m_hist[15] : ssp_dout_arm));
        chk({where, ".din"}, 32'(din_filtered), 32'(ssp_din_raw & (mt != 3'b010)));
    endtask

    task automatic do_reset(input logic [2:0] c);
        reset = 1'b1;
        cfg_mod_type = c;
        relay_in = 1'b0;
        ssp_dout_arm = 1'($urandom);
        @(posedge ck_1356meg); #1;
        model_clear();
        chk("rst.mod_type", 32'(mod_type), 32'(c));
        chk("rst.in_mod", 32'(in_mod), 32'd0);
        chk("rst.timeout", 32'(timeout), 32'd0);
        chk("rst.bit_strobe", 32'(bit_strobe), 32'd0);
        chk("rst.hisn", 32'(hisn_ssp_dout), 32'(is_relay(c) ? 1'b0 : ssp_dout_arm));
        @(posedge ck_1356meg); #1;
        reset = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic [2:0] c);
        logic sw;
        sw = c != cfg_mod_type;
        m_to = 1'b0;
        cfg_mod_type = c;
        relay_in = b;
        ssp_din_raw = 1'($urandom);
        ssp_dout_arm = 1'($urandom);
        @(posedge ck_1356meg); #1;
        if (sw) begin
            model_clear();
            check_outs("switch");
        end
        repeat (8) @(posedge ck_1356meg);
        #1;
        chk("bit_strobe", 32'(bit_strobe), 32'd1);
        @(posedge ck_1356meg); #1;
        model_bit(b);
        check_outs("bit");
        repeat (6) @(posedge ck_1356meg);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input logic [2:0] c);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i], c);
    endtask

    initial begin
        logic [2:0] pass_cfg [6];
        logic [2:0] c;
        pass_cfg = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
        model_clear();

        do_reset(3'b010);
        for (int i = 0; i < 20; i++) begin
            cfg_mod_type = (i < 6) ? 3'b010 : pass_cfg[$urandom_range(0, 5)];
            ssp_dout_arm = 1'($urandom);
            ssp_din_raw = 1'($urandom);
            #1;
            check_outs("passthru");
            @(posedge ck_1356meg); #1;
        end

        do_reset(3'b101);
        send_word(32'h0000C0, 24, 3'b101);
        send_word(32'($urandom_range(1, 255)), 8, 3'b101);
        send_word(32'h0, 32, 3'b101);

        send_word(32'h0000F0, 24, 3'b110);
        send_word(32'hA5, 8, 3'b110);
        send_word(32'h0, 24, 3'b110);

        send_word(32'h0000C0, 24, 3'b101);
        send_word(32'b101, 3, 3'b101);
        send_word(32'hC000_0000, 32, 3'b101);
        send_word(32'b11111, 5, 3'b101);
        send_word(32'hC000_0000, 32, 3'b101);

        send_word(32'h0000C0, 24, 3'b101);
        send_word(32'($urandom), 8, 3'b101);
        send_bit(1'b1, 3'b110);
        send_word(32'h0000F0, 24, 3'b110);
        send_word(32'($urandom), 8, 3'b110);
        do_reset(3'b110);

        for (int f = 0; f < 8; f++) begin
            c = ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b110;
            send_word(c == 3'b101 ? 32'h0000C0 : 32'h0000F0, 24, c);
            send_word($urandom, 8 * $urandom_range(1, 3), c);
            if (f == 3) send_word(32'($urandom), 8, 3'b000);
            send_word(32'h0, 32, c);
        end

        do_reset(3'b101);
        send_word(32'h0000C0, 24, 3'b101);
        for (int i = 0; i < 100; i++) send_word(32'hFF, 8, 3'b101);
`ifdef RELAY_TIMEOUT_EN
        chk("mod_after_100_bytes", 32'(in_mod), 32'd0);
`else
        chk("mod_after_100_bytes", 32'(in_mod), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
